// File: rtl/cache_ctrl_pkg.sv
// Shared types and encodings for the L1 cache controller.
package cache_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } cache_state_t;

   localparam logic DIN_CPU   = 1'b0;
   localparam logic DIN_PMEM  = 1'b1;
   localparam logic PADDR_CPU = 1'b0;
   localparam logic PADDR_WB  = 1'b1;

   function automatic logic [1:0] way_onehot(input logic w);
      return w ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc && !(&count))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back / write-allocate L1 cache,
// with saturating hit/miss/writeback counters.
module cache_control
   import cache_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [1:0]       way_hit,
   input  logic [1:0]       way_valid,
   input  logic [1:0]       way_dirty,
   input  logic             lru_in,
   input  logic             pmem_resp,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic [1:0]       data_load,
   output logic [1:0]       tag_load,
   output logic [1:0]       valid_set,
   output logic [1:0]       dirty_set,
   output logic [1:0]       dirty_clr,
   output logic             lru_load,
   output logic             lru_out,
   output logic             data_in_sel,
   output logic             pmem_addr_sel,
   output logic             way_sel,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);

   cache_state_t state, next_state;
   logic victim;
   logic rst_d;
   logic out_en;
   logic req, hit, hw, need_wb;
   logic hit_inc, miss_inc, wb_inc;

   // Outputs and transitions are held off for the reset cycle and the one after.
   assign out_en  = ~reset & ~rst_d;
   assign req     = mem_read | mem_write;
   assign hit     = |way_hit;
   assign hw      = ~way_hit[0];
   assign need_wb = way_valid[lru_in] & way_dirty[lru_in];

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         victim <= 1'b0;
         rst_d  <= 1'b1;
      end else begin
         state <= next_state;
         rst_d <= 1'b0;
         if (out_en && state == IDLE && req && !hit)
            victim <= lru_in;
      end
   end

   always_comb begin
      next_state = state;
      if (!out_en) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:      if (req && !hit) next_state = need_wb ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (pmem_resp) next_state = ALLOCATE;
            ALLOCATE:  if (pmem_resp) next_state = IDLE;
            default:   next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      data_load     = 2'b00;
      tag_load      = 2'b00;
      valid_set     = 2'b00;
      dirty_set     = 2'b00;
      dirty_clr     = 2'b00;
      lru_load      = 1'b0;
      lru_out       = 1'b0;
      data_in_sel   = DIN_CPU;
      pmem_addr_sel = PADDR_CPU;
      way_sel       = 1'b0;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;
      wb_inc        = 1'b0;
      if (out_en) begin
         case (state)
            IDLE: begin
               if (req && hit) begin
                  mem_resp = 1'b1;
                  way_sel  = hw;
                  lru_load = 1'b1;
                  lru_out  = ~hw;
                  hit_inc  = 1'b1;
                  if (mem_write) begin
                     data_load   = way_onehot(hw);
                     dirty_set   = way_onehot(hw);
                     data_in_sel = DIN_CPU;
                  end
               end else if (req) begin
                  miss_inc = 1'b1;
                  wb_inc   = need_wb;
               end
            end
            WRITEBACK: begin
               pmem_write    = 1'b1;
               pmem_addr_sel = PADDR_WB;
               way_sel       = victim;
            end
            ALLOCATE: begin
               pmem_read     = 1'b1;
               pmem_addr_sel = PADDR_CPU;
               data_in_sel   = DIN_PMEM;
               if (pmem_resp) begin
                  data_load = way_onehot(victim);
                  tag_load  = way_onehot(victim);
                  valid_set = way_onehot(victim);
                  dirty_clr = way_onehot(victim);
               end
            end
            default: ;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_hit_cnt (
      .clk(clk), .reset(reset), .inc(hit_inc), .count(hit_count)
   );
   sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clk(clk), .reset(reset), .inc(miss_inc), .count(miss_count)
   );
   sat_counter #(.W(CNT_W)) u_wb_cnt (
      .clk(clk), .reset(reset), .inc(wb_inc), .count(wb_count)
   );

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: requests push expected completions,
// a monitor pops them when mem_resp fires; a responder models pmem latency.
module tb_cache_control;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             mem_read = 1'b0, mem_write = 1'b0;
   logic [1:0]       way_hit = 2'b00, way_valid = 2'b00, way_dirty = 2'b00;
   logic             lru_in = 1'b0;
   logic             pmem_resp = 1'b0;
   logic             mem_resp, pmem_read, pmem_write;
   logic [1:0]       data_load, tag_load, valid_set, dirty_set, dirty_clr;
   logic             lru_load, lru_out, data_in_sel, pmem_addr_sel, way_sel;
   logic [CNT_W-1:0] hit_count, miss_count, wb_count;

   cache_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
      .lru_in(lru_in), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .data_load(data_load),
      .tag_load(tag_load), .valid_set(valid_set), .dirty_set(dirty_set),
      .dirty_clr(dirty_clr), .lru_load(lru_load), .lru_out(lru_out),
      .data_in_sel(data_in_sel), .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      logic hw;
      logic wr;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   n_chk = 0, n_err = 0;
   int   rd_lat = 1, wr_lat = 1;
   int   m_hit = 0, m_miss = 0, m_wb = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] oh(input logic w);
      return w ? 2'b10 : 2'b01;
   endfunction

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   // pmem responder: pulse pmem_resp on the Nth cycle of a read/write phase
   initial begin
      int  cnt;
      bit  was;
      cnt = 0;
      forever begin
         @(posedge clk); #1;
         was = pmem_resp;
         pmem_resp = 1'b0;
         if (was) cnt = 0;
         if (pmem_read) begin
            cnt++;
            if (cnt == rd_lat) pmem_resp = 1'b1;
         end else if (pmem_write) begin
            cnt++;
            if (cnt == wr_lat) pmem_resp = 1'b1;
         end else begin
            cnt = 0;
         end
      end
   end

   // completion monitor
   always @(negedge clk) begin
      if (pmem_read || pmem_write) chk("pmem_excl", {31'd0, pmem_read & pmem_write}, 0);
      if (mem_resp) begin
         if (sbq.size() == 0) begin
            chk("spurious_resp", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("resp_cycle", cyc, e.cyc);
            chk("resp_way_sel", {31'd0, way_sel}, {31'd0, e.hw});
            chk("resp_lru_load", {31'd0, lru_load}, 1);
            chk("resp_lru_out", {31'd0, lru_out}, {31'd0, ~e.hw});
            chk("resp_data_load", {30'd0, data_load}, e.wr ? {30'd0, oh(e.hw)} : 0);
            chk("resp_dirty_set", {30'd0, dirty_set}, e.wr ? {30'd0, oh(e.hw)} : 0);
            if (e.wr) chk("resp_din_sel", {31'd0, data_in_sel}, 0);
         end
      end
   end

   // One CPU request; entered and left at posedge+2.
   task automatic xact(input bit rd, input bit wr, input logic [1:0] hit,
                       input logic [1:0] vld, input logic [1:0] drt, input logic lru,
                       input int wl, input int rl);
      bit   miss, wb, done, fill;
      logic v, hw;
      int   nrd, nwr, lat;
      exp_t e;
      miss = (hit == 2'b00);
      v    = lru;
      wb   = miss && vld[v] && drt[v];
      hw   = miss ? v : ~hit[0];
      lat  = miss ? ((wb ? wl : 0) + rl + 1) : 0;
      rd_lat = rl; wr_lat = wl;
      mem_read = rd; mem_write = wr;
      way_hit = hit; way_valid = vld; way_dirty = drt; lru_in = lru;
      e.cyc = cyc + lat; e.hw = hw; e.wr = wr;
      sbq.push_back(e);
      done = 0; fill = 0; nrd = 0; nwr = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (pmem_write) begin
            nwr++;
            chk("wb_addr_sel", {31'd0, pmem_addr_sel}, 1);
            chk("wb_way_sel", {31'd0, way_sel}, {31'd0, v});
         end
         if (pmem_read) begin
            nrd++;
            chk("fill_addr_sel", {31'd0, pmem_addr_sel}, 0);
            if (pmem_resp) begin
               fill = 1;
               chk("fill_data_load", {30'd0, data_load}, {30'd0, oh(v)});
               chk("fill_tag_load", {30'd0, tag_load}, {30'd0, oh(v)});
               chk("fill_valid_set", {30'd0, valid_set}, {30'd0, oh(v)});
               chk("fill_dirty_clr", {30'd0, dirty_clr}, {30'd0, oh(v)});
               chk("fill_din_sel", {31'd0, data_in_sel}, 1);
            end
         end
         if (mem_resp) done = 1;
         @(posedge clk); #2;
         if (miss) lru_in = ~lru;  // victim must stay latched
         if (fill) begin
            way_hit = oh(v); way_valid[v] = 1'b1; way_dirty[v] = 1'b0;
            fill = 0;
         end
         if (done) break;
      end
      if (!done) chk("timeout", 0, 1);
      mem_read = 0; mem_write = 0; way_hit = 2'b00;
      chk("rd_cycles", nrd, miss ? rl : 0);
      chk("wr_cycles", nwr, wb ? wl : 0);
      m_hit = sat(m_hit);
      if (miss) m_miss = sat(m_miss);
      if (wb) m_wb = sat(m_wb);
      chk("hit_count", {28'd0, hit_count}, m_hit);
      chk("miss_count", {28'd0, miss_count}, m_miss);
      chk("wb_count", {28'd0, wb_count}, m_wb);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      // reset with a hitting read held: must stay quiet through the cycle after
      mem_read = 1; way_hit = 2'b01; way_valid = 2'b01;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_resp", {31'd0, mem_resp}, 0);
      chk("rst_lru_load", {31'd0, lru_load}, 0);
      @(posedge clk); #2;
      reset = 0;
      @(negedge clk);
      chk("post_rst_mem_resp", {31'd0, mem_resp}, 0);
      chk("post_rst_pmem", {30'd0, pmem_read, pmem_write}, 0);
      chk("post_rst_hit_count", {28'd0, hit_count}, 0);
      @(posedge clk); #2;
      mem_read = 0; way_hit = 2'b00;
      @(posedge clk); #2;

      xact(1, 0, 2'b10, 2'b11, 2'b00, 1'b1, 1, 1);  // read hit way1
      xact(0, 1, 2'b01, 2'b11, 2'b00, 1'b0, 1, 1);  // write hit way0
      xact(1, 0, 2'b00, 2'b01, 2'b00, 1'b0, 1, 5);  // clean read miss
      xact(0, 1, 2'b00, 2'b11, 2'b10, 1'b1, 3, 2);  // dirty write miss
      xact(1, 1, 2'b10, 2'b11, 2'b00, 1'b0, 1, 1);  // both high -> write
      xact(1, 0, 2'b11, 2'b11, 2'b00, 1'b1, 1, 1);  // way0 priority

      // reset while in ALLOCATE
      rd_lat = 50;
      mem_read = 1; way_hit = 2'b00; way_valid = 2'b01; way_dirty = 2'b00; lru_in = 0;
      repeat (3) begin @(negedge clk); @(posedge clk); #2; end
      @(negedge clk);
      chk("pre_rst_pmem_read", {31'd0, pmem_read}, 1);
      @(posedge clk); #2;
      reset = 1; mem_read = 0;
      @(negedge clk);
      chk("in_rst_pmem_read", {31'd0, pmem_read}, 0);
      chk("in_rst_data_load", {30'd0, data_load}, 0);
      @(posedge clk); #2;
      reset = 0;
      sbq.delete();
      m_hit = 0; m_miss = 0; m_wb = 0;
      @(negedge clk);
      chk("rst2_pmem_read", {31'd0, pmem_read}, 0);
      chk("rst2_data_load", {30'd0, data_load}, 0);
      chk("rst2_counters", {20'd0, hit_count, miss_count, wb_count}, 0);
      @(posedge clk); #2;
      @(negedge clk);
      chk("idle_pmem_read", {31'd0, pmem_read}, 0);
      @(posedge clk); #2;

      // hit counter saturation
      for (int i = 0; i < (1 << CNT_W) + 3; i++)
         xact(1, 0, 2'b01, 2'b01, 2'b00, 1'b0, 1, 1);
      chk("hit_saturated", {28'd0, hit_count}, CMAX);
      chk("sb_drained", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
